// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction-fetch sequencer.
//
// Selects the next PC from one of five sources. The sources, in priority
// order, are: reset, stall hold, illegal-op trap, interrupt trap, and the
// pc_sel choice (sequential, branch, jump or register jump). PC[31] is the
// kernel bit. Only jr/jalr from kernel code, a trap vector, or reset can
// change it.
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-low
//   stall      in   1   hold pc/epc/retired, suppress traps this cycle
//   pc_sel     in   2   0 seq, 1 branch, 2 jump, 3 register jump
//   branch_imm in  32   sign-extended branch offset in words
//   jump_index in  26   instr[25:0]
//   jr_target  in  32   rs value for jr/jalr
//   irq        in   1   level interrupt request (taken only in user mode)
//   illop      in   1   current instruction is undefined
//   pc         out 32   current PC / ROM byte address
//   pc_plus4   out 32   {pc[31], pc[30:0]+4}
//   trap       out  1   a trap is taken at the coming edge
//   irq_ack    out  1   the trap being taken is an interrupt
//   kernel     out  1   pc[31]
//   epc        out 32   pc_plus4 captured by the last trap
//   retired    out 32   completed-instruction counter
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] branch_imm,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic        irq,
  input  logic        illop,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        trap,
  output logic        irq_ack,
  output logic        kernel,
  output logic [31:0] epc,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_JREG   = 2'd3
  } pc_sel_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] retired_q, retired_d;

  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_tgt;
  logic        irq_take;
  logic        unused_bits;

  // Offset bits above [28] shift out of the 31-bit address field.
  assign unused_bits = ^branch_imm[31:29];

  // Address arithmetic is confined to bits [30:0]; bit 31 is carried
  // unchanged so sequential flow and branches never change mode.
  assign pc_plus4  = {pc_q[31], pc_q[30:0] + 31'd4};
  assign br_target = {pc_q[31], pc_plus4[30:0] + {branch_imm[28:0], 2'b00}};
  assign j_target  = {pc_plus4[31:28], jump_index, 2'b00};
  // User code cannot raise the kernel bit through a register jump.
  assign jr_tgt    = {jr_target[31] & pc_q[31], jr_target[30:0]};

  assign irq_take = irq & ~pc_q[31];
  assign trap     = reset & ~stall & (illop | irq_take);
  assign irq_ack  = reset & ~stall & ~illop & irq_take;

  assign pc      = pc_q;
  assign kernel  = pc_q[31];
  assign epc     = epc_q;
  assign retired = retired_q;

  always_comb begin
    pc_d      = pc_q;
    epc_d     = epc_q;
    retired_d = retired_q;
    if (!stall) begin
      if (illop) begin
        pc_d  = EXC_VEC;
        epc_d = pc_plus4;
      end else if (irq_take) begin
        pc_d  = IRQ_VEC;
        epc_d = pc_plus4;
      end else begin
        retired_d = retired_q + 32'd1;
        unique case (pc_sel_e'(pc_sel))
          SEL_SEQ:    pc_d = pc_plus4;
          SEL_BRANCH: pc_d = br_target;
          SEL_JUMP:   pc_d = j_target;
          SEL_JREG:   pc_d = jr_tgt;
          default:    pc_d = pc_plus4;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      epc_q     <= '0;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: the driver pushes the model's expected
// outputs for each cycle; a monitor pops and compares them mid-cycle.
module tb_pc_fetch;

  localparam logic [31:0] RST_V = 32'h8000_0000;
  localparam logic [31:0] IRQ_V = 32'h8000_0004;
  localparam logic [31:0] EXC_V = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  pc_sel = '0;
  logic [31:0] branch_imm = '0;
  logic [25:0] jump_index = '0;
  logic [31:0] jr_target = '0;
  logic        irq = 1'b0;
  logic        illop = 1'b0;
  logic [31:0] pc, pc_plus4, epc, retired;
  logic        trap, irq_ack, kernel;

  pc_fetch #(.RESET_PC(RST_V), .IRQ_VEC(IRQ_V), .EXC_VEC(EXC_V)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel),
    .branch_imm(branch_imm), .jump_index(jump_index), .jr_target(jr_target),
    .irq(irq), .illop(illop), .pc(pc), .pc_plus4(pc_plus4), .trap(trap),
    .irq_ack(irq_ack), .kernel(kernel), .epc(epc), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, pc4, epc, ret;
    logic        trap, ack, kern;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state: the architectural registers after the last edge.
  logic [31:0] m_pc  = RST_V;
  logic [31:0] m_epc = '0;
  logic [31:0] m_ret = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, queue the expected
  // outputs for this cycle, then advance the model across the next edge.
  task automatic drive(input bit rst, input bit st, input logic [1:0] sel,
                       input logic [31:0] bimm, input logic [25:0] jidx,
                       input logic [31:0] jrt, input bit rq, input bit ill);
    exp_t        e;
    logic [31:0] low;
    longint      br;
    bit          user_irq;
    @(negedge clk);
    reset = rst; stall = st; pc_sel = sel; branch_imm = bimm;
    jump_index = jidx; jr_target = jrt; irq = rq; illop = ill;

    low      = m_pc & 32'h7FFF_FFFF;
    user_irq = rq && (m_pc < 32'h8000_0000);
    e.pc   = m_pc;
    e.pc4  = (m_pc & 32'h8000_0000) | ((low + 32'd4) & 32'h7FFF_FFFF);
    e.epc  = m_epc;
    e.ret  = m_ret;
    e.kern = (m_pc >= 32'h8000_0000);
    e.trap = rst && !st && (ill || user_irq);
    e.ack  = rst && !st && !ill && user_irq;
    sb.push_back(e);

    if (!rst) begin
      m_pc = RST_V; m_epc = 0; m_ret = 0;
    end else if (st) begin
      // everything held
    end else if (ill) begin
      m_epc = e.pc4; m_pc = EXC_V;
    end else if (user_irq) begin
      m_epc = e.pc4; m_pc = IRQ_V;
    end else begin
      m_ret = m_ret + 1;
      case (sel)
        2'd0: m_pc = e.pc4;
        2'd1: begin
          br = longint'(low) + 4 + longint'($signed(bimm)) * 4;
          m_pc = (m_pc & 32'h8000_0000) | (32'(br) & 32'h7FFF_FFFF);
        end
        2'd2: m_pc = (e.pc4 & 32'hF000_0000) | (32'(jidx) * 4);
        default: m_pc = (jrt & 32'h7FFF_FFFF) | (jrt & m_pc & 32'h8000_0000);
      endcase
    end
  endtask

  // Monitor: every cycle the DUT presents a new set of outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_plus4", pc_plus4, e.pc4);
        chk("epc", epc, e.epc);
        chk("retired", retired, e.ret);
        chk("trap", 32'(trap), 32'(e.trap));
        chk("irq_ack", 32'(irq_ack), 32'(e.ack));
        chk("kernel", 32'(kernel), 32'(e.kern));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    // Reset held for two cycles.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // Jump from the reset vector.
    drive(1, 0, 2, 0, 26'h00000B, 0, 0, 0);
    #2; chk("rst_pc", pc, 32'h8000_0000); chk("rst_kernel", 32'(kernel), 32'd1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #2; chk("jump_pc", pc, 32'h8000_002C); chk("jump_retired", retired, 32'd1);
    // Kernel to user via jr, then user cannot set the kernel bit.
    drive(1, 0, 3, 0, 0, 32'h0000_0034, 0, 0);
    #2; chk("seq_pc", pc, 32'h8000_0030);
    drive(1, 0, 3, 0, 0, 32'h8000_0010, 0, 0);
    #2; chk("jr_user_pc", pc, 32'h0000_0034); chk("jr_user_kernel", 32'(kernel), 32'd0);
    drive(1, 0, 2, 0, 26'h000015, 0, 0, 0);
    #2; chk("jr_block_pc", pc, 32'h0000_0010);
    // Interrupt in user mode, irq then held in kernel.
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    #2; chk("irq_pc", pc, 32'h0000_0054); chk("irq_trap", 32'(trap), 32'd1);
    chk("irq_ack", 32'(irq_ack), 32'd1);
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    #2; chk("irq_vec", pc, 32'h8000_0004); chk("irq_epc", epc, 32'h0000_0058);
    chk("irq_retired", retired, 32'd5); chk("kern_irq_trap", 32'(trap), 32'd0);
    drive(1, 0, 3, 0, 0, 32'h0000_0100, 1, 0);
    #2; chk("kern_adv_pc", pc, 32'h8000_0008); chk("kern_adv_trap", 32'(trap), 32'd0);
    // Simultaneous illop and irq.
    drive(1, 0, 2, 0, 26'h3FFFFFF, 0, 1, 1);
    #2; chk("ill_pc", pc, 32'h0000_0100); chk("ill_trap", 32'(trap), 32'd1);
    chk("ill_ack", 32'(irq_ack), 32'd0);
    drive(1, 0, 3, 0, 0, 32'h0000_0104, 1, 0);
    #2; chk("ill_vec", pc, 32'h8000_0008); chk("ill_epc", epc, 32'h0000_0104);
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    #2; chk("ret_pc", pc, 32'h0000_0104); chk("ret_irq_trap", 32'(trap), 32'd1);
    // Stall with irq pending, then a backward branch.
    drive(1, 0, 3, 0, 0, 32'h0000_0040, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 32'h0000_0010, 0, 0, 1, 0);
      #2; chk("stall_pc", pc, 32'h0000_0040); chk("stall_trap", 32'(trap), 32'd0);
      chk("stall_epc", epc, 32'h0000_0108);
    end
    drive(1, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #2; chk("branch_pc", pc, 32'h0000_003C);
    // Counter wrap: preload the counter after the edge.
    @(posedge clk); #1;
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    m_ret = 32'hFFFF_FFFF;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #2; chk("wrap_pre", retired, 32'hFFFF_FFFF);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #2; chk("wrap_zero", retired, 32'd0);
    // Reset asserted during a would-be trap.
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    #2; chk("rst_trap", 32'(trap), 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #2; chk("rst2_pc", pc, RST_V); chk("rst2_epc", epc, 32'd0); chk("rst2_ret", retired, 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) == 0),
            2'(r[1:0]), {{16{r[31]}}, r[31:16]}, 26'($urandom),
            (r[2] ? $urandom : (32'($urandom_range(0, 255)) << 2)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    end

    @(negedge clk); #3;
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
